// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// stall-vector polarity and bit positions, reset polarity and zero word.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_D = 2'd1,
    ST_BUS_I = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0;

  // Stall vector bit that holds each pipeline stage
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// bus_timeout_ctr: counts cycles of an open bus cycle.
//   clk, rst : clock, async active-high reset
//   clr      : return the count to zero (bus idle)
//   en       : count this cycle (bus cycle open)
//   tc       : this is the TMO_CYC-th cycle without completion; the cycle
//              must be aborted at the coming edge unless acked
module bus_timeout_ctr
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) cnt_q <= '0;
    else                   cnt_q <= cnt_d;
  end

  // Count starts at 0 in the first bus cycle, so TMO_CYC-1 marks the last one
  assign tc = en && (cnt_q == CW'(TMO_CYC - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat cyc/stb/ack bus between the fetch
// (IF) and load/store (MEM) ports.
//   stall/flush            : pipeline hold vector and exception flush
//   if_*                   : fetch request, result word, stall request
//   mem_*                  : data request, load result, stall request
//   bus_*                  : registered bus master outputs, ack/data in,
//                            bus_err pulses one cycle on timeout
// Each port gets one result register + valid flag; a result is held until
// its stage advances (stall bit low) and is dropped on flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] if_rdata,
  output logic              stallreq_if,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_mem,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [DATA_W-1:0] bus_dat_o,
  input  logic [DATA_W-1:0] bus_dat_i,
  input  logic              bus_ack,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_o_q, dat_o_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_valid_q, i_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              tmo;
  logic              unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  bus_timeout_ctr #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .en  (state_q != ST_IDLE),
    .tc  (tmo)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_o_d   = dat_o_q;
    err_d     = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // Stage advancing consumes the held result; a result landing on the
    // same edge is set below and wins.
    i_valid_d = i_valid_q && (stall[STALL_IF] == STOP);
    d_valid_d = d_valid_q && (stall[STALL_MEM] == STOP);

    case (state_q)
      ST_IDLE: begin
        // No grant during flush: both requests belong to squashed insns.
        // MEM first: it belongs to the older instruction.
        if (!flush && mem_ce && !d_valid_q) begin
          state_d = ST_BUS_D;
          cyc_d   = 1'b1;
          we_d    = mem_we;
          sel_d   = mem_sel;
          adr_d   = mem_addr;
          dat_o_d = mem_wdata;
        end else if (!flush && if_ce && !i_valid_q) begin
          state_d = ST_BUS_I;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = '1;
          adr_d   = if_addr;
          dat_o_d = '0;
        end
      end
      ST_BUS_D, ST_BUS_I: begin
        if (bus_ack || tmo) begin
          // Ack beats a coincident timeout; flush on the same edge drops data
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          err_d   = !bus_ack;
          if (!flush && state_q == ST_BUS_D) begin
            d_rdata_d = bus_ack ? bus_dat_i : DATA_W'(ZERO_WORD);
            d_valid_d = 1'b1;
          end else if (!flush) begin
            i_rdata_d = bus_ack ? ADDR_W'(bus_dat_i) : ADDR_W'(ZERO_WORD);
            i_valid_d = 1'b1;
          end
        end else if (flush) begin
          // A bus cycle cannot be withdrawn; let it finish and discard it
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus_ack || tmo) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          err_d   = !bus_ack;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      i_valid_d = 1'b0;
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_o_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_o_q   <= dat_o_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      i_valid_q <= i_valid_d;
      d_rdata_q <= d_rdata_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign bus_cyc      = cyc_q;
  assign bus_stb      = cyc_q;
  assign bus_we       = we_q;
  assign bus_sel      = sel_q;
  assign bus_adr      = adr_q;
  assign bus_dat_o    = dat_o_q;
  assign bus_err      = err_q;
  assign if_rdata     = i_rdata_q;
  assign mem_rdata    = d_rdata_q;
  assign stallreq_if  = if_ce && !i_valid_q && !flush;
  assign stallreq_mem = mem_ce && !d_valid_q && !flush;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter. A driver issues held requests per
// port, random stalls and flushes; a bus slave answers each cycle after a
// random wait or not at all; a negedge monitor keeps a transaction-level
// model (per-port "result held" flag and expected-result queue) and checks.
module tb_mem_bus_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8, TMO = 4, LIVE = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          if_ce, mem_ce, mem_we;
  logic [AW-1:0] if_addr, if_rdata, mem_addr, bus_adr;
  logic [SW-1:0] mem_sel, bus_sel;
  logic [DW-1:0] mem_wdata, mem_rdata, bus_dat_o, bus_dat_i;
  logic          stallreq_if, stallreq_mem, bus_cyc, bus_stb, bus_we, bus_ack, bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata), .stallreq_if(stallreq_if),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_adr(bus_adr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus slave ----------------
  int            force_w = -1;
  int            cur_w = 0, k = 0;
  logic [DW-1:0] cur_d = '0;
  bit            in_cyc = 0;

  initial begin
    bus_ack = 1'b0; bus_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus_cyc) begin
        bus_ack = 1'b0; in_cyc = 0;
      end else begin
        if (!in_cyc) begin
          in_cyc = 1; k = 0;
          cur_w = (force_w >= 0) ? force_w : int'($urandom_range(0, TMO + 1));
          cur_d = $urandom;
          bus_dat_i = cur_d;
        end else k++;
        bus_ack = (k == cur_w);   // waits >= TMO never ack: timeout
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  logic [DW-1:0] qi[$], qd[$], tmp;
  bit            served_i, served_d, snap_i, snap_d, prev_cyc, ended, rst_chk;
  bit            cyc_port, cyc_flushed, cyc_tmo, exp_we;
  int            cyc_len, cyc_exp_len, wait_i, wait_d, lat_n;
  int            cons_i_cnt = 0, cons_d_cnt = 0;
  bit            lat_go = 0;
  logic [SW-1:0] exp_sel, s_mem_sel;
  logic [AW-1:0] exp_adr, s_if_addr, s_mem_addr;
  logic [DW-1:0] exp_dat, s_mem_wdata;
  logic          s_mem_we;

  always @(negedge clk) begin
    if (rst) begin
      prev_cyc = 0; served_i = 0; served_d = 0; snap_i = 0; snap_d = 0;
      qi.delete(); qd.delete(); wait_i = 0; wait_d = 0; lat_n = 0;
      cyc_tmo = 0; cyc_flushed = 0; cyc_len = 0; cyc_exp_len = 0; rst_chk = 1;
      exp_we = 0; exp_sel = '0; exp_adr = '0; exp_dat = '0;
    end else begin
      if (rst_chk) begin
        rst_chk = 0;
        chk("rst_cyc", {bus_cyc, bus_stb, bus_we, bus_err}, 4'b0);
        chk("rst_bus_fields", {bus_sel, bus_adr}, 0);
        chk("rst_dat_o", bus_dat_o, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("rst_stallreq", {stallreq_if, stallreq_mem}, 2'b00);
      end
      if (lat_go && lat_n < 3) begin
        lat_n++;
        case (lat_n)
          1: chk("lat_c0_stallreq_if", stallreq_if, 1);
          2: chk("lat_c1_cyc", bus_cyc, 1);
          default: chk("lat_c2_stallreq_if", stallreq_if, 0);
        endcase
      end
      // bus cycle end: result becomes held unless it was flushed
      ended = prev_cyc && !bus_cyc;
      if (ended) begin
        chk("cyc_len", cyc_len, cyc_exp_len);
        if (!cyc_flushed) begin
          if (cyc_port) served_d = 1; else served_i = 1;
        end
      end
      chk("bus_err", bus_err, ended && cyc_tmo);
      chk("stb_eq_cyc", bus_stb, bus_cyc);
      // bus cycle start: grant decided from last cycle's pending requests
      if (!prev_cyc && bus_cyc) begin
        chk("grant_pending", snap_i || snap_d, 1);
        cyc_port = snap_d; cyc_len = 0; cyc_flushed = 0;
        cyc_tmo = (cur_w >= TMO);
        cyc_exp_len = cyc_tmo ? TMO : cur_w + 1;
        exp_we  = snap_d && s_mem_we;
        exp_sel = snap_d ? s_mem_sel : {SW{1'b1}};
        exp_adr = snap_d ? s_mem_addr : s_if_addr;
        exp_dat = s_mem_wdata;
        if (snap_d) qd.push_back(cyc_tmo ? '0 : cur_d);
        else        qi.push_back(cyc_tmo ? '0 : cur_d);
      end
      if (bus_cyc) begin
        cyc_len++;
        chk("bus_ctl", {bus_we, bus_sel, bus_adr}, {exp_we, exp_sel, exp_adr});
        if (exp_we) chk("bus_dat_o", bus_dat_o, exp_dat);
      end
      prev_cyc = bus_cyc;
      chk("stallreq_if", stallreq_if, if_ce && !served_i && !flush);
      chk("stallreq_mem", stallreq_mem, mem_ce && !served_d && !flush);
      if (served_i && qi.size() > 0) chk("if_rdata", if_rdata, qi[0]);
      if (served_d && qd.size() > 0) chk("mem_rdata", mem_rdata, qd[0]);
      // pending requests as the arbiter sees them at the coming edge
      snap_i = if_ce && !served_i && !flush;
      snap_d = mem_ce && !served_d && !flush;
      s_if_addr = if_addr; s_mem_addr = mem_addr; s_mem_we = mem_we;
      s_mem_sel = mem_sel; s_mem_wdata = mem_wdata;
      // progress watchdog
      if (if_ce && !flush) wait_i++; else wait_i = 0;
      if (mem_ce && !flush) wait_d++; else wait_d = 0;
      chk("if_progress", wait_i < LIVE, 1);
      chk("mem_progress", wait_d < LIVE, 1);
      // stage advance consumes a held result
      if (!flush && served_i && !stall[1]) begin
        if (qi.size() > 0) tmp = qi.pop_front();
        served_i = 0; wait_i = 0; cons_i_cnt++;
      end
      if (!flush && served_d && !stall[4]) begin
        if (qd.size() > 0) tmp = qd.pop_front();
        served_d = 0; wait_d = 0; cons_d_cnt++;
      end
      if (flush) begin
        qi.delete(); qd.delete(); served_i = 0; served_d = 0;
        if (bus_cyc) cyc_flushed = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic new_if();
    if_ce   = ($urandom % 3) != 0;
    if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_mem();
    mem_ce    = ($urandom % 3) != 0;
    mem_we    = $urandom % 2;
    mem_sel   = SW'($urandom_range(1, (1 << SW) - 1));
    mem_addr  = $urandom;
    mem_wdata = $urandom;
  endtask

  initial begin
    int  seen_i, seen_d;
    bit  heavy;
    rst = 1'b1; stall = '0; flush = 1'b0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // zero-wait fetch with IF held: result two cycles after ce rises
    force_w = 0; stall = 6'b000010; if_ce = 1'b1; if_addr = 32'h0000_0040; lat_go = 1;
    repeat (4) @(posedge clk);
    #1 stall = '0;
    seen_i = 0; seen_d = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      force_w = -1;
      heavy = (c >= 1500);
      if (flush) begin
        flush = 1'b0; new_if(); new_mem();
      end else begin
        if (cons_i_cnt != seen_i || !if_ce) new_if();
        if (cons_d_cnt != seen_d || !mem_ce) new_mem();
        flush = (c < 2800) && (($urandom % (heavy ? 15 : 60)) == 0);
      end
      seen_i = cons_i_cnt; seen_d = cons_d_cnt;
      stall    = 6'($urandom);
      stall[1] = ($urandom % 4) < (heavy ? 3 : 1);
      stall[4] = ($urandom % 4) < (heavy ? 3 : 1);
    end
    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
